popcount_stream: RTL and testbench

POPCOUNT_STREAM -- requirements
Module: popcount_stream

---
 rtl/popcount_pkg.sv | 15 +
 rtl/popcnt_chunk.sv | 17 +
 rtl/popcount_stream.sv | 115 +++++++++++
 tb/tb_popcount_stream.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared FSM state encoding and count-width helper for popcount_stream
package popcount_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width needed to hold any count from 0 to data_w inclusive.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// rtl/popcnt_chunk.sv - combinational population count of one CHUNK_W-bit slice
module popcnt_chunk #(
  parameter  int CHUNK_W = 8,
  localparam int PC_W    = $clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] i_chunk,
  output logic [PC_W-1:0]    o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      o_count = o_count + PC_W'(i_chunk[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// rtl/popcount_stream.sv - multi-cycle popcount of a word, one CHUNK_W slice per beat,
// with threshold compare and a saturating counter of delivered over-threshold results
module popcount_stream
  import popcount_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int CHUNK_W = 8,
  localparam int CNT_W   = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ge,
  output logic [15:0]       ge_events
);

  localparam int NBEATS = DATA_W / CHUNK_W;
  localparam int PC_W   = $clog2(CHUNK_W + 1);
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
    $error("popcount_stream: CHUNK_W must divide DATA_W exactly");
  end

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_thresh;
  logic [CNT_W-1:0]    r_acc;
  logic [BEAT_W-1:0]   r_beat;
  logic [CNT_W-1:0]    r_out_count;
  logic                r_out_ge;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [15:0]         r_ge_events;

  logic [PC_W-1:0]     w_chunk_cnt;
  logic [CNT_W-1:0]    w_sum;

  popcnt_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .i_chunk (r_shift[CHUNK_W-1:0]),
    .o_count (w_chunk_cnt)
  );

  // Accumulator never overflows: the full sum is at most DATA_W, which CNT_W holds.
  assign w_sum = r_acc + CNT_W'(w_chunk_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_thresh    <= '0;
      r_acc       <= '0;
      r_beat      <= '0;
      r_out_count <= '0;
      r_out_ge    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ge_events <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shift    <= in_data;
            r_thresh   <= in_thresh;
            r_acc      <= '0;
            r_beat     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          r_acc   <= w_sum;
          r_shift <= r_shift >> CHUNK_W;
          r_beat  <= r_beat + 1'b1;
          if (r_beat == BEAT_W'(NBEATS - 1)) begin
            r_out_count <= w_sum;
            r_out_ge    <= (w_sum >= r_thresh);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (r_out_ge && (r_ge_events != 16'hFFFF)) begin
              r_ge_events <= r_ge_events + 16'd1;
            end
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_ge    = r_out_ge;
  assign ge_events = r_ge_events;

endmodule

// File: tb/tb_popcount_stream.sv
// tb/tb_popcount_stream.sv - bench for popcount_stream: 32/8 and 64/16 instances share one stimulus stream
module tb_popcount_stream;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;
  logic [6:0]  in_thresh;

  logic        in_ready_a, out_valid_a, out_ge_a;
  logic [5:0]  out_count_a;
  logic [15:0] ge_events_a;
  logic        in_ready_b, out_valid_b, out_ge_b;
  logic [6:0]  out_count_b;
  logic [15:0] ge_events_b;

  always #5 clk = ~clk;

  popcount_stream dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data[31:0]),
    .in_thresh (in_thresh[5:0]),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_count (out_count_a),
    .out_ge    (out_ge_a),
    .ge_events (ge_events_a)
  );

  popcount_stream #(
    .DATA_W  (64),
    .CHUNK_W (16)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_thresh (in_thresh),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_count (out_count_b),
    .out_ge    (out_ge_b),
    .ge_events (ge_events_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit m_init = 1'b0;

  // Transaction-level model: a word accepted in cycle n is presented from cycle n+LAT until consumed.
  bit m_pend [2];
  int m_acc  [2];
  int m_cnt  [2];
  bit m_ge   [2];
  int m_gev  [2];
  bit m_zero [2];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_count(input int i, input logic [63:0] d);
    logic [31:0] lo;
    lo = d[31:0];
    return (i == 0) ? $countones(lo) : $countones(d);
  endfunction

  function automatic int ref_thresh(input int i, input logic [6:0] t);
    logic [5:0] lo;
    lo = t[5:0];
    return (i == 0) ? int'(lo) : int'(t);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pend[i] <= 1'b0;
        m_gev[i]  <= 0;
        m_zero[i] <= 1'b1;
      end else if (m_init) begin
        if (!m_pend[i]) begin
          if (in_valid) begin
            m_pend[i] <= 1'b1;
            m_acc[i]  <= cyc;
            m_cnt[i]  <= ref_count(i, in_data);
            m_ge[i]   <= ref_count(i, in_data) >= ref_thresh(i, in_thresh);
          end
        end else if (cyc >= m_acc[i] + LAT && out_ready) begin
          m_pend[i] <= 1'b0;
          m_zero[i] <= 1'b0;
          if (m_ge[i] && m_gev[i] < 65535) m_gev[i] <= m_gev[i] + 1;
        end
      end
    end
    if (rst) m_init <= 1'b1;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        bit ev;
        ev = m_pend[i] && (cyc >= m_acc[i] + LAT);
        check($sformatf("in_ready[%0d]", i), (i == 0) ? in_ready_a : in_ready_b, !m_pend[i]);
        check($sformatf("out_valid[%0d]", i), (i == 0) ? out_valid_a : out_valid_b, ev);
        if (ev) begin
          check($sformatf("out_count[%0d]", i), (i == 0) ? out_count_a : out_count_b, m_cnt[i]);
          check($sformatf("out_ge[%0d]", i), (i == 0) ? out_ge_a : out_ge_b, m_ge[i]);
        end else if (m_zero[i]) begin
          check($sformatf("rst_count[%0d]", i), (i == 0) ? out_count_a : out_count_b, 0);
          check($sformatf("rst_ge[%0d]", i), (i == 0) ? out_ge_a : out_ge_b, 0);
        end
        check($sformatf("ge_events[%0d]", i), (i == 0) ? ge_events_a : ge_events_b, m_gev[i]);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [6:0] t, input bit rdy, output int acc_c);
    int k = 0;
    while (!in_ready_a && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", in_ready_a, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_thresh = t;
    out_ready = rdy;
    acc_c     = cyc;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = ~d;
    in_thresh = ~t;
  endtask

  task automatic wait_valid(input int acc_c);
    int k = 0;
    while (!out_valid_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", cyc - acc_c, LAT);
  endtask

  task automatic run_vec(input string name, input logic [63:0] d, input logic [6:0] t,
                         input int e_cnt, input int e_ge, input int e_gev);
    int ac;
    send(d, t, 1'b1, ac);
    wait_valid(ac);
    check({name, "_cnt"}, out_count_a, e_cnt);
    check({name, "_ge"}, out_ge_a, e_ge);
    @(negedge clk);
    check({name, "_gev"}, ge_events_a, e_gev);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ac;
    logic [63:0] pat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_thresh = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready_a, 1);
    check("reset_in_ready_w64", in_ready_b, 1);
    check("reset_out_valid", out_valid_a, 0);
    check("reset_out_count", out_count_a, 0);
    check("reset_ge_events", ge_events_a, 0);

    run_vec("upper_half", 64'h0000_0000_FFFF_0000, 7'd16, 16, 1, 1);
    run_vec("low15", 64'h0000_0000_0000_7FFF, 7'd16, 15, 0, 1);
    run_vec("thr_equal", 64'h0000_0000_FFFF_FFFF, 7'd32, 32, 1, 2);
    run_vec("thr_over", 64'h0000_0000_FFFF_FFFF, 7'd40, 32, 0, 2);

    pulse_reset();
    check("rst2_ge_events", ge_events_a, 0);
    run_vec("all_ones", 64'h0000_0000_FFFF_FFFF, 7'd0, 32, 1, 1);
    run_vec("all_zero", 64'h0, 7'd0, 0, 1, 2);

    // Consumer stalls for 10 cycles; the result must hold.
    send(64'h0000_0000_F0F0_F0F0, 7'd20, 1'b0, ac);
    wait_valid(ac);
    repeat (10) begin
      check("hold_valid", out_valid_a, 1);
      check("hold_count", out_count_a, 16);
      check("hold_ready", in_ready_a, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_consumed", out_valid_a, 0);
    check("hold_gev", ge_events_a, 2);

    // Reset during the second COUNT beat discards the word.
    send(64'h0000_0000_0000_FFFF, 7'd0, 1'b1, ac);
    @(negedge clk);
    pulse_reset();
    check("abort_in_ready", in_ready_a, 1);
    check("abort_out_valid", out_valid_a, 0);
    check("abort_out_count", out_count_a, 0);
    check("abort_ge_events", ge_events_a, 0);
    repeat (8) begin
      check("abort_no_valid", out_valid_a, 0);
      @(negedge clk);
    end

    // Wide instance: 64-bit alternating pattern.
    send(64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 1'b1, ac);
    wait_valid(ac);
    check("w64_count", out_count_b, 32);
    check("w64_ge", out_ge_b, 1);
    check("w64_narrow_count", out_count_a, 16);
    check("w64_narrow_ge", out_ge_a, 0);
    @(negedge clk);

    // Back-to-back: in_valid held high with a changing word every cycle.
    pat = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 40; k++) begin
      in_valid  = 1'b1;
      in_data   = pat;
      in_thresh = 7'(k % 34);
      pat       = {pat[58:0], pat[63:59]} ^ 64'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
